// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the multi-cycle MIPS datapath:
// 2^ADDR_WIDTH registers of DATA_WIDTH bits, two independent combinational
// read ports and one synchronous write port.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero (writes ignored, reads 0)
//   undefined -> register 0 is an ordinary read/write register
//
// Ports:
//   clk     - single clock, writes happen on its rising edge
//   rst     - asynchronous active-high reset, clears every register
//   we      - write enable
//   waddr   - write address
//   wdata   - write data
//   read1   - read port 1 enable (output forced to 0 when low)
//   raddr1  - read port 1 address
//   rdata1  - read port 1 data
//   read2   - read port 2 enable (output forced to 0 when low)
//   raddr2  - read port 2 address
//   rdata2  - read port 2 data
// ---------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  read2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];

  logic writeOk;
  logic read1Ok;
  logic read2Ok;

`ifdef REGFILE_ZERO_REG_EN
  // Register 0 is a constant zero: block writes to it and mask reads of it.
  assign writeOk = we && (waddr != '0);
  assign read1Ok = read1 && (raddr1 != '0);
  assign read2Ok = read2 && (raddr2 != '0);
`else
  assign writeOk = we;
  assign read1Ok = read1;
  assign read2Ok = read2;
`endif

  // Next-state: only the addressed register takes the write data.
  always_comb begin
    regs_d = regs_q;
    if (writeOk) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage; reset clears everything immediately and overrides any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads with no write bypass; disabled ports drive zero.
  assign rdata1 = read1Ok ? regs_q[raddr1] : '0;
  assign rdata2 = read2Ok ? regs_q[raddr2] : '0;

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//
// Self-checking bench for regfile. A reference array tracks what each
// register should hold; every read drives both ports, pushes the expected
// values onto a scoreboard queue and pops them once the outputs settle.
// ---------------------------------------------------------------------------
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        read1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        read2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [31:0] model [32];
  string       tagQ [$];
  logic [31:0] expQ [$];
  int          checkCount;
  int          passCount;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .read1  (read1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .read2  (read2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // What a port should show for a given enable/address given the model.
  function automatic logic [31:0] expRead(input logic en, input logic [4:0] a);
    if (!en) return 32'h0;
    if (ZeroReg && a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  // Wipe the reference model, mirroring what reset does to the storage.
  task automatic clearModel();
    foreach (model[i]) model[i] = 32'h0;
  endtask

  // Drive both read ports, queue the expectations, then score once settled.
  task automatic applyStimulus(input string tag, input logic r1,
                               input logic [4:0] a1, input logic r2,
                               input logic [4:0] a2);
    read1  = r1;
    raddr1 = a1;
    read2  = r2;
    raddr2 = a2;
    tagQ.push_back({tag, ".p1"});
    expQ.push_back(expRead(r1, a1));
    tagQ.push_back({tag, ".p2"});
    expQ.push_back(expRead(r2, a2));
    #1;
    checkOutput(tagQ.pop_front(), rdata1, expQ.pop_front());
    checkOutput(tagQ.pop_front(), rdata2, expQ.pop_front());
  endtask

  // One clocked write; leaves time at rising edge + 1 with we dropped.
  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    waddr = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (!(ZeroReg && a == 5'd0)) model[a] = d;
  endtask

  // Main sequence following the register-file test plan.
  initial begin
    checkCount = 0;
    passCount  = 0;
    clearModel();
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = 5'd0;
    wdata  = 32'h0;
    read1  = 1'b0;
    raddr1 = 5'd0;
    read2  = 1'b0;
    raddr2 = 5'd0;

    // Reset held for two cycles, then released away from a rising edge.
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("inReset", 1'b1, 5'd4, 1'b1, 5'd31);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("resetRead", 1'b1, 5'd4, 1'b1, 5'd31);

    // Basic write and read back on both ports.
    doWrite(5'd4, 32'hccffccff);
    applyStimulus("basic", 1'b1, 5'd4, 1'b1, 5'd31);
    checkOutput("basicConst", rdata1, 32'hccffccff);

    // Read enable gating on each port.
    applyStimulus("gate1Off", 1'b0, 5'd4, 1'b1, 5'd4);
    applyStimulus("gate1On", 1'b1, 5'd4, 1'b1, 5'd4);
    applyStimulus("gate2Off", 1'b1, 5'd4, 1'b0, 5'd4);
    applyStimulus("gate2On", 1'b1, 5'd4, 1'b1, 5'd4);

    // Several registers including both address extremes.
    doWrite(5'd31, 32'hffffffff);
    doWrite(5'd0, 32'hffff0000);
    doWrite(5'd13, 32'h0000ffff);
    doWrite(5'd7, 32'hcccccccc);
    applyStimulus("multiA", 1'b1, 5'd31, 1'b1, 5'd0);
    applyStimulus("multiB", 1'b1, 5'd13, 1'b1, 5'd7);
    applyStimulus("sameAddr", 1'b1, 5'd7, 1'b1, 5'd7);

    // Overwrites: last write wins.
    doWrite(5'd31, 32'h66666666);
    doWrite(5'd0, 32'h88888888);
    applyStimulus("overwrite", 1'b1, 5'd31, 1'b1, 5'd0);
    checkOutput("overwriteConst", rdata1, 32'h66666666);

    // With we low, an edge must not disturb anything.
    waddr = 5'd4;
    wdata = 32'hdeadbeef;
    we    = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("noWrite", 1'b1, 5'd4, 1'b1, 5'd13);

    // No bypass: old value before the edge, new value after it.
    waddr = 5'd13;
    wdata = 32'h12345678;
    we    = 1'b1;
    applyStimulus("preEdge", 1'b1, 5'd13, 1'b1, 5'd4);
    @(posedge clk);
    #1;
    we = 1'b0;
    model[13] = 32'h12345678;
    applyStimulus("postEdge", 1'b1, 5'd13, 1'b1, 5'd4);

    // Asynchronous reset mid-cycle with a write pending.
    waddr = 5'd5;
    wdata = 32'ha5a5a5a5;
    we    = 1'b1;
    #2;
    rst = 1'b1;
    clearModel();
    applyStimulus("asyncRst", 1'b1, 5'd4, 1'b1, 5'd31);
    @(posedge clk);
    #1;
    applyStimulus("rstHoldsWrite", 1'b1, 5'd5, 1'b1, 5'd13);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("afterRst", 1'b1, 5'd5, 1'b1, 5'd0);

    // First write after reset release lands normally.
    doWrite(5'd9, 32'h0badf00d);
    applyStimulus("postRstWrite", 1'b1, 5'd9, 1'b0, 5'd9);

    if (tagQ.size() != 0) begin
      checkOutput("queueDrained", 32'(tagQ.size()), 32'h0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
